// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: word-organised SRAM with byte-lane writes, programmable
// wait states, two-cycle ERROR responses and write-to-read forwarding.
module ahb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [2:0]            state, state_nxt;
  logic [2:0]            wcnt;
  logic [IDX_W-1:0]      idx_p0, idx_p1, rd_idx;
  logic [1:0]            alo_p1;
  logic                  write_p1;
  logic [2:0]            size_p1;
  logic                  err_p1;
  logic                  accept, acc_err;
  logic                  wr_en, rd_load, fwd;
  logic [3:0]            wr_mask;
  logic [DATA_WIDTH-1:0] rd_word, rd_data, hrdata_r;
  logic                  unused_ok;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_mask = 4'b0001 << a;
      3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [3:0] mask);
    lane_merge = old_w;
    for (int b = 0; b < 4; b++)
      if (mask[b]) lane_merge[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  // address phase (p0): decode and legality check
  assign unused_ok = ^{HBURST, HTRANS[0]};
  assign idx_p0    = HADDR[IDX_W+1:2];
  assign accept    = HSEL & HTRANS[1] & HREADY &
                     ((state == S_IDLE) | (state == S_DATA) | (state == S_ERR2));
  assign acc_err   = ({2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH)) |
                     (HSIZE > 3'd2) |
                     ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept)
          state_nxt = acc_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
        else
          state_nxt = S_IDLE;
      end
      S_WAIT:  if (wcnt == 3'd0) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // data phase (p1): write path and read fetch with forwarding of the in-flight write
  assign wr_en   = (state == S_DATA) & write_p1 & ~err_p1;
  assign wr_mask = lane_mask(size_p1, alo_p1);
  assign rd_idx  = (state == S_WAIT) ? idx_p1 : idx_p0;
  assign rd_load = (state_nxt == S_DATA) & ((state == S_WAIT) ? ~write_p1 : ~HWRITE);
  assign rd_word = mem[rd_idx];
  assign fwd     = wr_en & (idx_p1 == rd_idx);
  assign rd_data = fwd ? lane_merge(rd_word, HWDATA, wr_mask) : rd_word;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wcnt     <= 3'd0;
      idx_p1   <= '0;
      alo_p1   <= 2'b00;
      write_p1 <= 1'b0;
      size_p1  <= 3'd0;
      err_p1   <= 1'b0;
      hrdata_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_p1   <= idx_p0;
        alo_p1   <= HADDR[1:0];
        write_p1 <= HWRITE;
        size_p1  <= HSIZE;
        err_p1   <= acc_err;
        wcnt     <= WS_LAST;
      end else if ((state == S_WAIT) && (wcnt != 3'd0)) begin
        wcnt <= wcnt - 3'd1;
      end
      if (rd_load) hrdata_r <= rd_data;
    end
  end

  // memory is not reset; a reset edge suppresses the commit of an in-flight write
  always_ff @(posedge HCLK) begin
    if (HRESETn && wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) mem[idx_p1][8*b +: 8] <= HWDATA[8*b +: 8];
  end

  assign HRDATA    = hrdata_r;
  assign HREADYOUT = ~((state == S_WAIT) | (state == S_ERR1));
  assign HRESP     = (state == S_ERR1) | (state == S_ERR2);

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one instance with one wait state, one with none,
// driven as an AHB master with a data-phase scoreboard.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        sel_g;
  logic        which;
  logic        hold;

  logic        hsel1, hsel0, bus_ready;
  logic [31:0] rd1, rd0, hrdata_m;
  logic        ro1, ro0, rs1, rs0, hresp_m;

  typedef struct packed {
    logic        resp;
    logic        rdchk;
    logic [31:0] rdata;
    logic [3:0]  waits;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 hclk = ~hclk;

  assign hsel1     = sel_g & which;
  assign hsel0     = sel_g & ~which;
  assign bus_ready = hold ? 1'b0 : (which ? ro1 : ro0);
  assign hresp_m   = which ? rs1 : rs0;
  assign hrdata_m  = which ? rd1 : rd0;

  ahb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(bus_ready),
    .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1)
  );

  ahb_slave_mem #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(bus_ready),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one address phase; retire the previous data phase against the scoreboard.
  task automatic issue(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [31:0] wd, input logic sel,
                       input logic er, input logic rdchk, input logic [31:0] rexp);
    int   w;
    bit   done;
    exp_t e;
    htrans = tr; haddr = a; hwrite = wr; hsize = sz; sel_g = sel;
    w = 0; done = 0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge hclk);
      if (sb.size() > 0) chk("hresp", 32'(hresp_m), 32'(sb[0].resp));
      if (bus_ready) done = 1;
      else w++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("waits", 32'(w), 32'(e.waits));
      if (e.rdchk) chk("hrdata", hrdata_m, e.rdata);
    end
    @(posedge hclk);
    #1;
    hwdata = wd;
    e.resp  = er;
    e.rdchk = rdchk;
    e.rdata = rexp;
    e.waits = (tr[1] && sel) ? (er ? 4'd1 : (which ? 4'd1 : 4'd0)) : 4'd0;
    sb.push_back(e);
  endtask

  task automatic wr_w(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    issue(2'b10, a, 1'b1, sz, wd, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd_w(input logic [31:0] a, input logic [31:0] exp);
    issue(2'b10, a, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 1'b1, exp);
  endtask

  task automatic idle();
    issue(2'b00, 32'h0, 1'b0, 3'd2, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    hresetn = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd1; hwdata = '0; sel_g = 1'b0; which = 1'b1; hold = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_ready1", 32'(ro1), 32'd1);
    chk("rst_resp1",  32'(rs1), 32'd0);
    chk("rst_rdata1", rd1, 32'h0);
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_resp0",  32'(rs0), 32'd0);
    chk("rst_rdata0", rd0, 32'h0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;

    // one wait state: basic write/read, byte lanes, errors
    wr_w(32'h10, 3'd2, 32'hDEADBEEF);
    rd_w(32'h10, 32'hDEADBEEF);
    wr_w(32'h10, 3'd2, 32'h11223344);
    wr_w(32'h13, 3'd0, 32'hAA5A5A5A);
    rd_w(32'h10, 32'hAA223344);
    wr_w(32'h12, 3'd1, 32'h5566A5A5);
    rd_w(32'h10, 32'h55663344);
    wr_w(32'h00, 3'd2, 32'h00C0FFEE);
    issue(2'b10, 32'h02,  1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0);
    issue(2'b10, 32'h00,  1'b1, 3'd3, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0);
    issue(2'b10, 32'h400, 1'b0, 3'd2, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0);
    issue(2'b10, 32'h11,  1'b1, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0);
    rd_w(32'h00, 32'h00C0FFEE);
    rd_w(32'h10, 32'h55663344);
    idle();

    // zero wait states: pipelined burst with forwarding
    which = 1'b0;
    idle();
    issue(2'b10, 32'h20, 1'b1, 3'd2, 32'h10000020, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(2'b11, 32'h24, 1'b1, 3'd2, 32'h10000024, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(2'b11, 32'h28, 1'b1, 3'd2, 32'h10000028, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(2'b11, 32'h2C, 1'b1, 3'd2, 32'h1000002C, 1'b1, 1'b0, 1'b0, 32'h0);
    rd_w(32'h2C, 32'h1000002C);
    wr_w(32'h20, 3'd0, 32'hCCCCCC77);
    rd_w(32'h20, 32'h10000077);
    rd_w(32'h24, 32'h10000024);
    issue(2'b10, 32'h400, 1'b0, 3'd2, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    rd_w(32'h28, 32'h10000028);
    idle();

    // BUSY mid-burst, HREADY low and HSEL low while idle
    issue(2'b10, 32'h30, 1'b1, 3'd2, 32'hB0B00030, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(2'b01, 32'h34, 1'b1, 3'd2, 32'hDEAD0034, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(2'b11, 32'h34, 1'b1, 3'd2, 32'hB0B00034, 1'b1, 1'b0, 1'b0, 32'h0);
    wr_w(32'h60, 3'd2, 32'hCAFE0060);
    idle();
    hold = 1'b1; htrans = 2'b10; haddr = 32'h60; hwrite = 1'b1; hsize = 3'd2;
    sel_g = 1'b1; hwdata = 32'hBAD0BAD0;
    for (int c = 0; c < 2; c++) begin
      @(negedge hclk);
      chk("hold_ready", 32'(ro0), 32'd1);
      chk("hold_resp",  32'(rs0), 32'd0);
    end
    @(posedge hclk);
    #1;
    htrans = 2'b00; hold = 1'b0;
    issue(2'b10, 32'h60, 1'b1, 3'd2, 32'hBAD00060, 1'b0, 1'b0, 1'b0, 32'h0);
    rd_w(32'h30, 32'hB0B00030);
    rd_w(32'h34, 32'hB0B00034);
    rd_w(32'h60, 32'hCAFE0060);
    idle();

    // reset during the wait cycle of a write
    which = 1'b1;
    idle();
    wr_w(32'h40, 3'd2, 32'h0BADF00D);
    rd_w(32'h40, 32'h0BADF00D);
    wr_w(32'h40, 3'd2, 32'h11111111);
    htrans = 2'b00;
    hresetn = 1'b0;
    @(posedge hclk);
    #1;
    chk("rstw_ready", 32'(ro1), 32'd1);
    chk("rstw_resp",  32'(rs1), 32'd0);
    chk("rstw_rdata", rd1, 32'h0);
    hresetn = 1'b1;
    sb.delete();
    rd_w(32'h40, 32'h0BADF00D);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
